// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
// Optional sticky illegal-instruction trap enabled by defining EXEC_TRAP_EN.
module execute_cycle #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_PC_TGT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            ALUSrcE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            BranchE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] ImmExt_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RD_E,
  input  logic            IllegalOpE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
`ifdef EXEC_TRAP_EN
  output logic            TrapM,
`endif
  output logic            IllegalOpM
);

  logic [XLEN-1:0] src_a, write_data_e, src_b, alu_result_e;
  logic            zero_e, kill_ctrl;

  logic            reg_write_d, reg_write_q;
  logic            mem_write_d, mem_write_q;
  logic            result_src_d, result_src_q;
  logic            illegal_d, illegal_q;
  logic [4:0]      rd_d, rd_q;
  logic [XLEN-1:0] alu_result_d, alu_result_q;
  logic [XLEN-1:0] write_data_d, write_data_q;
  logic [XLEN-1:0] pc_plus4_d, pc_plus4_q;
`ifdef EXEC_TRAP_EN
  logic            trap_d, trap_q;
`endif

  // Select 11 is unused by the hazard unit and falls back to the decode value.
  always_comb begin
    src_a = RD1_E;
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = alu_result_q;
      default: src_a = RD1_E;
    endcase
    write_data_e = RD2_E;
    case (ForwardBE)
      2'b01:   write_data_e = ResultW;
      2'b10:   write_data_e = alu_result_q;
      default: write_data_e = RD2_E;
    endcase
    src_b = ALUSrcE ? ImmExt_E : write_data_e;
  end

  always_comb begin
    alu_result_e = '0;
    case (ALUControlE)
      3'b000: alu_result_e = src_a + src_b;
      3'b001: alu_result_e = src_a - src_b;
      3'b010: alu_result_e = src_a & src_b;
      3'b011: alu_result_e = src_a | src_b;
      3'b100: alu_result_e = src_a ^ src_b;
      3'b101: alu_result_e = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      3'b110: alu_result_e = src_a << src_b[4:0];
      3'b111: alu_result_e = src_a >> src_b[4:0];
      default: alu_result_e = '0;
    endcase
  end

  assign zero_e    = (alu_result_e == '0);
  assign PCTargetE = PCE + ImmExt_E;

`ifdef EXEC_TRAP_EN
  // Once trapped, branches and architectural writes are suppressed for good.
  assign PCSrcE    = BranchE & zero_e & ~trap_q;
  assign kill_ctrl = trap_q | IllegalOpE;
  assign trap_d    = trap_q | (IllegalOpE & ~FlushM);
`else
  assign PCSrcE    = BranchE & zero_e;
  assign kill_ctrl = 1'b0;
`endif

  always_comb begin
    reg_write_d  = RegWriteE & ~FlushM & ~kill_ctrl;
    mem_write_d  = MemWriteE & ~FlushM & ~kill_ctrl;
    result_src_d = ResultSrcE & ~FlushM;
    illegal_d    = IllegalOpE & ~FlushM;
    rd_d         = RD_E;
    alu_result_d = alu_result_e;
    write_data_d = write_data_e;
    pc_plus4_d   = PCPlus4E;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      illegal_q    <= 1'b0;
      rd_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= RESET_PC_TGT;
`ifdef EXEC_TRAP_EN
      trap_q       <= 1'b0;
`endif
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      illegal_q    <= illegal_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
`ifdef EXEC_TRAP_EN
      trap_q       <= trap_d;
`endif
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign IllegalOpM = illegal_q;
  assign RD_M       = rd_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;
`ifdef EXEC_TRAP_EN
  assign TrapM      = trap_q;
`endif

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed scenarios plus randomized traffic against a reference model.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, IllegalOpE, FlushM;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, ImmExt_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM, IllegalOpM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
`ifdef EXEC_TRAP_EN
  logic        TrapM;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: what the EX/MEM register should hold
  logic [31:0] exp_alu, exp_wd, exp_pc4;
  logic [4:0]  exp_rd;
  logic        exp_rw, exp_mw, exp_rs, exp_ill, exp_trap;

  localparam logic [31:0] RESET_PC = 32'h0;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExt_E(ImmExt_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RD_E(RD_E), .IllegalOpE(IllegalOpE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .FlushM(FlushM),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
`ifdef EXEC_TRAP_EN
    .TrapM(TrapM),
`endif
    .IllegalOpM(IllegalOpM)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] dec);
    if (sel == 2'd1) return ResultW;
    if (sel == 2'd2) return exp_alu;
    return dec;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return a << (b % 32);
      default: return a >> (b % 32);
    endcase
  endfunction

  function automatic logic [31:0] model_result();
    logic [31:0] b;
    b = ALUSrcE ? ImmExt_E : fwd(ForwardBE, RD2_E);
    return alu_ref(ALUControlE, fwd(ForwardAE, RD1_E), b);
  endfunction

  function automatic logic model_pcsrc();
    return BranchE && (model_result() == 32'h0) && !exp_trap;
  endfunction

  task automatic model_reset();
    exp_alu = 0; exp_wd = 0; exp_pc4 = RESET_PC; exp_rd = 0;
    exp_rw = 0; exp_mw = 0; exp_rs = 0; exp_ill = 0; exp_trap = 0;
  endtask

  // Clock one edge and advance the model with the inputs present at that edge
  task automatic step();
    logic [31:0] r, wd;
    logic        kill;
    @(posedge clk);
    r  = model_result();
    wd = fwd(ForwardBE, RD2_E);
`ifdef EXEC_TRAP_EN
    kill = exp_trap || (IllegalOpE && !FlushM);
    exp_trap = exp_trap || (IllegalOpE && !FlushM);
`else
    kill = 1'b0;
`endif
    exp_alu = r; exp_wd = wd; exp_pc4 = PCPlus4E; exp_rd = RD_E;
    exp_rw  = RegWriteE && !FlushM && !kill;
    exp_mw  = MemWriteE && !FlushM && !kill;
    exp_rs  = ResultSrcE && !FlushM;
    exp_ill = IllegalOpE && !FlushM;
    #1;
  endtask

  task automatic set_idle();
    RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
    IllegalOpE = 0; FlushM = 0; ALUControlE = 3'd0;
    RD1_E = 0; RD2_E = 0; ImmExt_E = 0; PCE = 0; PCPlus4E = 0; ResultW = 0;
    RD_E = 0; ForwardAE = 0; ForwardBE = 0;
  endtask

  task automatic set_random();
    RegWriteE = 1'($urandom); ALUSrcE = 1'($urandom); MemWriteE = 1'($urandom);
    ResultSrcE = 1'($urandom); BranchE = 1'($urandom);
    FlushM = ($urandom_range(0, 3) == 0);
`ifdef EXEC_TRAP_EN
    IllegalOpE = 1'b0;
`else
    IllegalOpE = 1'($urandom);
`endif
    ALUControlE = 3'($urandom);
    RD1_E = $urandom; RD2_E = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
    ImmExt_E = $urandom; PCE = $urandom; PCPlus4E = $urandom; ResultW = $urandom;
    RD_E = 5'($urandom); ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    set_random();
    model_reset();
    #1;
    n_cmp++; if (ALUResultM !== 32'h0 || WriteDataM !== 32'h0 || RD_M !== 5'h0) begin
      n_fail++; $display("FAIL reset_data: alu=%h wd=%h rd=%h required 0", ALUResultM, WriteDataM, RD_M); end
    n_cmp++; if ({RegWriteM, MemWriteM, ResultSrcM, IllegalOpM} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 0000", {RegWriteM, MemWriteM, ResultSrcM, IllegalOpM}); end
    n_cmp++; if (PCPlus4M !== RESET_PC) begin
      n_fail++; $display("FAIL reset_pc4: got %h required %h", PCPlus4M, RESET_PC); end
    @(posedge clk); #1;
    n_cmp++; if (ALUResultM !== 32'h0 || RegWriteM !== 1'b0) begin
      n_fail++; $display("FAIL reset_held: alu=%h rw=%b required 0", ALUResultM, RegWriteM); end
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    RD1_E = 5; RD2_E = 7;
    step();
    n_cmp++; if (ALUResultM !== 32'd12) begin
      n_fail++; $display("FAIL reset_first_add: got %h required 0000000c", ALUResultM); end
  endtask

  task automatic test_forwarding();
    @(negedge clk); set_idle(); RD1_E = 32'h8; RD2_E = 32'h8; step();
    n_cmp++; if (ALUResultM !== 32'h10) begin
      n_fail++; $display("FAIL fwd_first: got %h required 00000010", ALUResultM); end
    @(negedge clk); set_idle(); ForwardAE = 2'b10; ImmExt_E = 4; ALUSrcE = 1; RD1_E = 32'h999; step();
    n_cmp++; if (ALUResultM !== 32'h14) begin
      n_fail++; $display("FAIL fwd_m_to_a: got %h required 00000014", ALUResultM); end
    @(negedge clk); set_idle(); ForwardBE = 2'b01; ResultW = 32'hDEAD; RD2_E = 32'h1234; MemWriteE = 1; step();
    n_cmp++; if (WriteDataM !== 32'hDEAD || MemWriteM !== 1'b1) begin
      n_fail++; $display("FAIL fwd_w_to_b: wd=%h mw=%b required 0000dead 1", WriteDataM, MemWriteM); end
    @(negedge clk); set_idle(); ForwardAE = 2'b11; RD1_E = 32'h3; ResultW = 32'h77; RD2_E = 32'h1; step();
    n_cmp++; if (ALUResultM !== 32'h4) begin
      n_fail++; $display("FAIL fwd_sel11: got %h required 00000004", ALUResultM); end
  endtask

  task automatic test_branch();
    @(negedge clk); set_idle();
    BranchE = 1; ALUControlE = 3'd1; RD1_E = 9; RD2_E = 9; PCE = 32'h100; ImmExt_E = 32'hFFFFFFF8;
    #1;
    n_cmp++; if (PCSrcE !== 1'b1 || PCTargetE !== 32'hF8) begin
      n_fail++; $display("FAIL branch_taken: pcsrc=%b tgt=%h required 1 000000f8", PCSrcE, PCTargetE); end
    RD2_E = 8; #1;
    n_cmp++; if (PCSrcE !== 1'b0) begin
      n_fail++; $display("FAIL branch_not_taken: got %b required 0", PCSrcE); end
    step();
  endtask

  task automatic test_alu_edges();
    @(negedge clk); set_idle(); ALUControlE = 3'd5; RD1_E = 32'hFFFFFFFF; RD2_E = 1; step();
    n_cmp++; if (ALUResultM !== 32'h1) begin
      n_fail++; $display("FAIL alu_slt: got %h required 00000001", ALUResultM); end
    @(negedge clk); set_idle(); ALUControlE = 3'd0; RD1_E = 32'hFFFFFFFF; RD2_E = 1; step();
    n_cmp++; if (ALUResultM !== 32'h0) begin
      n_fail++; $display("FAIL alu_add_wrap: got %h required 00000000", ALUResultM); end
    @(negedge clk); set_idle(); ALUControlE = 3'd6; RD1_E = 32'h3; RD2_E = 32'h21; step();
    n_cmp++; if (ALUResultM !== 32'h6) begin
      n_fail++; $display("FAIL alu_sll: got %h required 00000006", ALUResultM); end
    @(negedge clk); set_idle(); ALUControlE = 3'd7; RD1_E = 32'h80000000; ImmExt_E = 31; ALUSrcE = 1; step();
    n_cmp++; if (ALUResultM !== 32'h1) begin
      n_fail++; $display("FAIL alu_srl: got %h required 00000001", ALUResultM); end
  endtask

  task automatic test_flush();
    @(negedge clk); set_idle();
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; FlushM = 1; RD1_E = 32'h55; RD2_E = 32'h22; RD_E = 5'd9;
    step();
    n_cmp++; if ({RegWriteM, MemWriteM, ResultSrcM} !== 3'b000) begin
      n_fail++; $display("FAIL flush_ctrl: got %b required 000", {RegWriteM, MemWriteM, ResultSrcM}); end
    n_cmp++; if (ALUResultM !== 32'h77 || RD_M !== 5'd9) begin
      n_fail++; $display("FAIL flush_data: alu=%h rd=%0d required 00000077 9", ALUResultM, RD_M); end
`ifndef EXEC_TRAP_EN
    @(negedge clk); set_idle(); IllegalOpE = 1; step();
    n_cmp++; if (IllegalOpM !== 1'b1) begin
      n_fail++; $display("FAIL illegal_pass: got %b required 1", IllegalOpM); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 150) begin
        // Mid-stream reset discards in-flight EX/MEM contents
        rst = 1'b0; model_reset(); #1;
        n_cmp++; if (ALUResultM !== 32'h0 || RegWriteM !== 1'b0 || PCPlus4M !== RESET_PC) begin
          n_fail++; $display("FAIL mid_reset: alu=%h rw=%b pc4=%h", ALUResultM, RegWriteM, PCPlus4M); end
        @(negedge clk); rst = 1'b1;
      end
      set_random();
      #1;
      n_cmp++; if (PCSrcE !== model_pcsrc() || PCTargetE !== PCE + ImmExt_E) begin
        n_fail++; $display("FAIL rand_branch[%0d]: pcsrc=%b tgt=%h required %b %h",
                           i, PCSrcE, PCTargetE, model_pcsrc(), PCE + ImmExt_E); end
      step();
      n_cmp++; if (ALUResultM !== exp_alu || WriteDataM !== exp_wd || PCPlus4M !== exp_pc4 || RD_M !== exp_rd) begin
        n_fail++; $display("FAIL rand_data[%0d]: alu=%h wd=%h pc4=%h rd=%0d required %h %h %h %0d",
                           i, ALUResultM, WriteDataM, PCPlus4M, RD_M, exp_alu, exp_wd, exp_pc4, exp_rd); end
      n_cmp++; if ({RegWriteM, MemWriteM, ResultSrcM, IllegalOpM} !== {exp_rw, exp_mw, exp_rs, exp_ill}) begin
        n_fail++; $display("FAIL rand_ctrl[%0d]: got %b required %b", i,
                           {RegWriteM, MemWriteM, ResultSrcM, IllegalOpM}, {exp_rw, exp_mw, exp_rs, exp_ill}); end
    end
  endtask

`ifdef EXEC_TRAP_EN
  task automatic test_trap();
    @(negedge clk); set_idle(); IllegalOpE = 1; RegWriteE = 1; MemWriteE = 1; step();
    n_cmp++; if (TrapM !== 1'b1 || RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || IllegalOpM !== 1'b1) begin
      n_fail++; $display("FAIL trap_set: trap=%b rw=%b mw=%b ill=%b required 1 0 0 1", TrapM, RegWriteM, MemWriteM, IllegalOpM); end
    @(negedge clk); set_idle(); RegWriteE = 1; RD1_E = 1; RD2_E = 2; step();
    n_cmp++; if (TrapM !== 1'b1 || RegWriteM !== 1'b0 || ALUResultM !== 32'h3) begin
      n_fail++; $display("FAIL trap_sticky: trap=%b rw=%b alu=%h required 1 0 00000003", TrapM, RegWriteM, ALUResultM); end
    @(negedge clk); set_idle(); BranchE = 1; ALUControlE = 3'd1; RD1_E = 4; RD2_E = 4; #1;
    n_cmp++; if (PCSrcE !== 1'b0) begin
      n_fail++; $display("FAIL trap_branch: got %b required 0", PCSrcE); end
    rst = 1'b0; model_reset(); #1;
    n_cmp++; if (TrapM !== 1'b0) begin
      n_fail++; $display("FAIL trap_reset: got %b required 0", TrapM); end
    @(negedge clk); rst = 1'b1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    set_idle();
    rst = 1'b0;
    model_reset();
    test_reset();
    test_forwarding();
    test_branch();
    test_alu_edges();
    test_flush();
    test_random();
`ifdef EXEC_TRAP_EN
    test_trap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
